// File: rtl/vga_if.sv
// Video raster bundle between the timing source and the output stage.
// The master side drives the raster position, syncs and strobes.
interface vga_if;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       xhsync;
  logic       xvsync;
  logic       ins;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;
  logic       running;

  modport master (
    output CounterX, CounterY, xhsync, xvsync, ins,
    output line_start, frame_start, frame_cnt, running
  );

  modport slave (
    input CounterX, CounterY, xhsync, xvsync, ins,
    input line_start, frame_start, frame_cnt, running
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing with start/stop FSM that halts at frame end.
// All outputs are registered from the next (h,v) so they stay aligned.
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  pix_en,
  input  logic  enable,
  vga_if.master vo
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HVIS  = 10'(H_VIS);
  localparam logic [9:0] HS0   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] HLAST = 10'(H_TOT - 1);
  localparam logic [9:0] VVIS  = 10'(V_VIS);
  localparam logic [9:0] VS0   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] VLAST = 10'(V_TOT - 1);
  localparam logic       SON   = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nx, v_nx;
  logic       last;
  logic       frame_done;
  logic       act_nx;

  assign last   = (h_cnt == HLAST) && (v_cnt == VLAST);
  assign act_nx = (state_nx != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (pix_en)
      state <= state_nx;
  end

  // Next state and next raster position
  always_comb begin
    state_nx   = state;
    h_nx       = h_cnt;
    v_nx       = v_cnt;
    frame_done = 1'b0;
    if (pix_en) begin
      unique case (state)
        IDLE: begin
          h_nx = '0;
          v_nx = '0;
          if (enable)
            state_nx = RUN;
        end
        RUN, DRAIN: begin
          if (state == DRAIN && last && !enable) begin
            state_nx   = IDLE;
            h_nx       = '0;
            v_nx       = '0;
            frame_done = 1'b1;
          end else begin
            state_nx   = enable ? RUN : DRAIN;
            frame_done = last;
            if (h_cnt == HLAST) begin
              h_nx = '0;
              v_nx = (v_cnt == VLAST) ? '0 : v_cnt + 10'd1;
            end else begin
              h_nx = h_cnt + 10'd1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          h_nx     = '0;
          v_nx     = '0;
        end
      endcase
    end
  end

  // Position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_nx;
      v_cnt <= v_nx;
    end
  end

  // Registered outputs decoded from the next position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vo.CounterX    <= '0;
      vo.CounterY    <= 9'h1FF;
      vo.xhsync      <= ~SON;
      vo.xvsync      <= ~SON;
      vo.ins         <= 1'b0;
      vo.line_start  <= 1'b0;
      vo.frame_start <= 1'b0;
      vo.frame_cnt   <= '0;
      vo.running     <= 1'b0;
    end else if (pix_en) begin
      vo.CounterX    <= h_nx;
      vo.CounterY    <= (act_nx && v_nx < VVIS) ?
                        v_nx[8:0] : 9'h1FF;
      vo.xhsync      <= (act_nx && h_nx >= HS0 && h_nx < HS1) ?
                        SON : ~SON;
      vo.xvsync      <= (act_nx && v_nx >= VS0 && v_nx < VS1) ?
                        SON : ~SON;
      vo.ins         <= act_nx && (h_nx < HVIS) && (v_nx < VVIS);
      vo.line_start  <= act_nx && (h_nx == '0);
      vo.frame_start <= act_nx && (h_nx == '0) && (v_nx == '0);
      vo.running     <= act_nx;
      if (frame_done)
        vo.frame_cnt <= vo.frame_cnt + 8'd1;
    end else begin
      vo.line_start  <= 1'b0;
      vo.frame_start <= 1'b0;
    end
  end

endmodule
